// File: rtl/gpio_port_core.sv
// GPIO port core: a WIDTH-bit pin bank with output, enable and alternate-function
// registers, a per-pin synchroniser and debounce filter, and per-pin interrupts
// with level/edge and polarity selection plus sticky write-1-to-clear status.
module gpio_port_core #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] portin,
    output logic [WIDTH-1:0] portout,
    output logic [WIDTH-1:0] porten,
    output logic [WIDTH-1:0] portfunc,
    output logic [WIDTH-1:0] datain,
    output logic [WIDTH-1:0] gpioint,
    output logic             combint,
    input  logic             reg_we,
    input  logic [2:0]       reg_addr,
    input  logic [WIDTH-1:0] reg_wdata,
    output logic [WIDTH-1:0] reg_rdata
);

    // Counter just wide enough to hold DB_CYCLES-1; a change is accepted on the
    // cycle the counter has already seen DB_CYCLES-1 mismatching samples.
    localparam int            CW      = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    localparam logic [2:0] ADDR_DATAOUT = 3'd0;
    localparam logic [2:0] ADDR_OUTEN   = 3'd1;
    localparam logic [2:0] ADDR_ALTFUNC = 3'd2;
    localparam logic [2:0] ADDR_INTEN   = 3'd3;
    localparam logic [2:0] ADDR_INTTYPE = 3'd4;
    localparam logic [2:0] ADDR_INTPOL  = 3'd5;
    localparam logic [2:0] ADDR_INTSTAT = 3'd6;
    localparam logic [2:0] ADDR_DATAIN  = 3'd7;

    logic [WIDTH-1:0] dataout_q;
    logic [WIDTH-1:0] outen_q;
    logic [WIDTH-1:0] altfunc_q;
    logic [WIDTH-1:0] inten_q;
    logic [WIDTH-1:0] inttype_q;
    logic [WIDTH-1:0] intpol_q;
    logic [WIDTH-1:0] intstat_q;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] prev_q;
    logic [CW-1:0]    db_cnt_q [WIDTH];

    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] level_evt;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] w1c;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Control registers written from the register port; INTSTAT and DATAIN live elsewhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            dataout_q <= '0;
            outen_q   <= '0;
            altfunc_q <= '0;
            inten_q   <= '0;
            inttype_q <= '0;
            intpol_q  <= '0;
        end else if (reg_we) begin
            case (reg_addr)
                ADDR_DATAOUT: dataout_q <= reg_wdata;
                ADDR_OUTEN:   outen_q   <= reg_wdata;
                ADDR_ALTFUNC: altfunc_q <= reg_wdata;
                ADDR_INTEN:   inten_q   <= reg_wdata;
                ADDR_INTTYPE: inttype_q <= reg_wdata;
                ADDR_INTPOL:  intpol_q  <= reg_wdata;
                default:      ;
            endcase
        end
    end

    // Multi-flop synchroniser bringing the asynchronous pad inputs into clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= portin;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Per-pin debounce: a new level must persist DB_CYCLES samples; any reversion restarts.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_out[i] == stable_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    stable_q[i] <= sync_out[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Previous filtered value, so edges come only from pin activity and never from mode changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
        end else begin
            prev_q <= stable_q;
        end
    end

    // Per-pin event selection from edge/level mode and polarity, plus the W1C mask.
    always_comb begin
        rise      = stable_q & ~prev_q;
        fall      = ~stable_q & prev_q;
        edge_evt  = (intpol_q & rise) | (~intpol_q & fall);
        level_evt = (intpol_q & stable_q) | (~intpol_q & ~stable_q);
        evt       = (inttype_q & edge_evt) | (~inttype_q & level_evt);
        w1c       = (reg_we && (reg_addr == ADDR_INTSTAT)) ? reg_wdata : '0;
    end

    // Sticky status: a new enabled event wins over a simultaneous write-1-to-clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            intstat_q <= '0;
        end else begin
            intstat_q <= (inten_q & evt) | (intstat_q & ~w1c);
        end
    end

    // Combinational read mux over the register map.
    always_comb begin
        reg_rdata = '0;
        case (reg_addr)
            ADDR_DATAOUT: reg_rdata = dataout_q;
            ADDR_OUTEN:   reg_rdata = outen_q;
            ADDR_ALTFUNC: reg_rdata = altfunc_q;
            ADDR_INTEN:   reg_rdata = inten_q;
            ADDR_INTTYPE: reg_rdata = inttype_q;
            ADDR_INTPOL:  reg_rdata = intpol_q;
            ADDR_INTSTAT: reg_rdata = intstat_q;
            ADDR_DATAIN:  reg_rdata = stable_q;
            default:      reg_rdata = '0;
        endcase
    end

    assign portout  = dataout_q;
    assign porten   = outen_q;
    assign portfunc = altfunc_q;
    assign datain   = stable_q;
    assign gpioint  = intstat_q;
    assign combint  = |intstat_q;

endmodule

// File: doc/gpio_port_core.md
Name: gpio_port_core

Overview:
- Parametrised successor to the 16-bit GPIO port: WIDTH-bit pin bank behind a simple register write/read port.
- Per-pin input synchroniser and glitch filter (debounce).
- Per-pin interrupt with level/edge and polarity selection, sticky status with write-1-to-clear, and a combined interrupt.
- Sits between the AHB slave register decoder and the pad ring; drives portout/porten/portfunc, samples portin.

Parameters:
- WIDTH, 16, number of pins; range 1..32.
- SYNC_STAGES, 2, input synchroniser depth; range 2..4.
- DB_CYCLES, 3, consecutive cycles a synchronised change must persist before it is accepted; range 1..255; 1 means no filtering.

Ports:
- clk  in  1  sole clock (AHB hclk domain)
- rst  in  1  synchronous reset, active high
- portin  in  WIDTH  asynchronous pad inputs
- portout  out  WIDTH  output data register
- porten  out  WIDTH  output enable register
- portfunc  out  WIDTH  alternate-function select register
- datain  out  WIDTH  synchronised, debounced pin values
- gpioint  out  WIDTH  per-pin interrupt status
- combint  out  1  OR of gpioint
- reg_we  in  1  register write strobe, single cycle
- reg_addr  in  3  register index
- reg_wdata  in  WIDTH  write data
- reg_rdata  out  WIDTH  read data, combinational from reg_addr

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high (rst). While rst is sampled high, every flop clears to 0. All outputs read 0 after the reset edge, and reg_rdata reads 0 for every address. Asserting rst mid-operation aborts debounce counts and clears all interrupt status on the same edge.
- Register map (addr: name):
  - 0 DATAOUT, 1 OUTEN, 2 ALTFUNC, 3 INTEN, 4 INTTYPE (1 = edge, 0 = level), 5 INTPOL (1 = high/rising, 0 = low/falling): read/write.
  - 6 INTSTAT: read; a write is W1C.
  - 7 DATAIN: read-only; writes ignored.
- Writes take effect at the edge where reg_we is sampled high. portout/porten/portfunc are direct register outputs with one-edge latency.
- Synchroniser: SYNC_STAGES flops per pin. sync_out reflects a portin value present before edge k at edge k+SYNC_STAGES-1.
- Debounce, per pin: stable register plus counter of ceil(log2(DB_CYCLES+1)) bits.
  - sync_out == stable: counter <= 0.
  - sync_out != stable and counter == DB_CYCLES-1: stable <= sync_out, counter <= 0.
  - otherwise: counter++.
  - Any reversion before acceptance restarts the count.
  - datain = stable.
  - Pin-to-datain latency: SYNC_STAGES+DB_CYCLES edges.
- Edge detect: prev register tracks stable each cycle.
  - rise = stable & ~prev; fall = ~stable & prev.
  - Changing INTTYPE/INTPOL never fabricates an edge.
- Event per pin:
  - edge mode: INTPOL ? rise : fall.
  - level mode: INTPOL ? stable : ~stable.
- INTSTAT[i] next-state:
  - set when INTEN[i] & event[i];
  - else cleared when a W1C write to addr 6 has bit i = 1;
  - else hold.
  - Set wins over a simultaneous clear. In level mode, clearing while the level persists leaves the bit at 1.
  - Clearing INTEN[i] does not clear INTSTAT[i]; it only blocks new sets.
- Outputs:
  - gpioint = INTSTAT, registered; appears one edge after stable changes, i.e. SYNC_STAGES+DB_CYCLES+1 edges after the pin change.
  - combint = |INTSTAT, combinational from the status flops, no extra latency.
- Write-data bits above WIDTH do not exist; reads of unused upper bits are not applicable. Address 7 writes have no side effects.

Test Plan (WIDTH=16, SYNC_STAGES=2, DB_CYCLES=3):
1. Reset: drive portin=0xFFFF, assert rst 2 cycles -> portout/porten/portfunc/gpioint=0x0000, combint=0, reg_rdata=0 at every addr; datain becomes 0xFFFF exactly 5 edges after rst falls.
2. Write DATAOUT=0xA5A5, OUTEN=0x00FF, ALTFUNC=0x0F00 -> each output updates at the write edge; readback addr 0/1/2 returns the same values; write to addr 7 leaves datain unchanged.
3. Debounce: portin[0] 0->1 for 2 cycles then back to 0 -> datain[0] stays 0. Hold portin[0]=1 -> datain[0]=1 exactly 5 edges after the change.
4. Rising edge: INTEN=0x0001, INTTYPE=0x0001, INTPOL=0x0001; portin[0] 0->1 -> gpioint=0x0001 and combint=1 at edge 6. W1C 0x0001 -> 0x0000 next edge. Subsequent falling edge -> status stays 0.
5. Low level, pin 3: INTEN=0x0008, INTTYPE=0, INTPOL=0, portin[3]=0 -> gpioint[3]=1; W1C 0x0008 while low -> remains 1; drive high, wait 5 edges, W1C -> 0.
6. Collision and reset: W1C bit 0 on the same edge a rising event sets it -> gpioint[0] stays 1; assert rst with status 0x0009 pending -> gpioint=0, combint=0 at the next edge.
